// File: rtl/m31_pkg.sv
// Shared M31 field definitions (p = 2^31 - 1) and vector-block state encoding.
package m31_pkg;

    localparam int unsigned M31_WIDTH = 31;
    localparam logic [M31_WIDTH-1:0] M31_P = 31'h7FFF_FFFF;

    typedef logic [M31_WIDTH-1:0] m31_t;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDrain,
        StDone
    } vs_state_e;

endpackage

// File: rtl/m31_mod_reduce.sv
// Combinational reduction of a 63-bit value modulo 2^31-1 to the canonical range [0, p-1].
module m31_mod_reduce
    import m31_pkg::*;
(
    input  logic [62:0] x_i,
    output m31_t        r_o
);

    logic [32:0] s1;
    logic [31:0] s2;
    logic [31:0] s3;

    // 2^31 == 1 (mod p), so each fold adds the high part onto the low 31 bits.
    always_comb begin
        s1  = 33'(x_i[30:0]) + 33'(x_i[62:31]);
        s2  = 32'(s1[30:0]) + 32'(s1[32:31]);
        s3  = 32'(s2[30:0]) + 32'(s2[31]);
        r_o = (s3 >= {1'b0, M31_P}) ? 31'(s3 - {1'b0, M31_P}) : s3[30:0];
    end

endmodule

// File: rtl/m31_multiplier_pl.sv
// Pipelined 31x31 -> 62-bit multiplier; the product appears STAGES cycles after the operands.
module m31_multiplier_pl
    import m31_pkg::*;
#(
    parameter int unsigned STAGES = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  m31_t        a_i,
    input  m31_t        b_i,
    output logic [61:0] p_o
);

    logic [STAGES-1:0][61:0] pipe_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pipe_q <= '0;
        end else begin
            pipe_q[0] <= {31'b0, a_i} * {31'b0, b_i};
            for (int i = 1; i < int'(STAGES); i++) begin
                pipe_q[i] <= pipe_q[i-1];
            end
        end
    end

    assign p_o = pipe_q[STAGES-1];

endmodule

// File: rtl/vector_issue_ctrl.sv
// Job FSM for vector blocks: issues one element index per cycle and tracks writebacks
// through an issue-valid delay line matched to the datapath latency.
module vector_issue_ctrl
    import m31_pkg::*;
#(
    parameter int unsigned VECTOR_SIZE = 16,
    parameter int unsigned LATENCY     = 2,
    parameter int unsigned IDX_W       = $clog2(VECTOR_SIZE)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start_i,
    output logic             load_o,
    output logic [IDX_W-1:0] issue_idx_o,
    output logic             wb_valid_o,
    output logic [IDX_W-1:0] wb_idx_o,
    output logic             busy_o,
    output logic             done_o
);

    localparam logic [IDX_W-1:0] LastIdx = IDX_W'(VECTOR_SIZE - 1);

    vs_state_e          state_q, state_d;
    logic [IDX_W-1:0]   issue_cnt_q, issue_cnt_d;
    logic [IDX_W-1:0]   wb_cnt_q, wb_cnt_d;
    logic [LATENCY-1:0] dly_q;
    logic               issue_valid;

    always_comb begin
        state_d     = state_q;
        issue_cnt_d = issue_cnt_q;
        wb_cnt_d    = wb_cnt_q;
        load_o      = 1'b0;
        issue_valid = 1'b0;
        wb_valid_o  = dly_q[LATENCY-1];

        if (wb_valid_o) begin
            wb_cnt_d = (wb_cnt_q == LastIdx) ? '0 : wb_cnt_q + 1'b1;
        end

        case (state_q)
            StIdle, StDone: begin
                if (start_i) begin
                    load_o      = 1'b1;
                    state_d     = StRun;
                    issue_cnt_d = '0;
                    wb_cnt_d    = '0;
                end
            end
            StRun: begin
                issue_valid = 1'b1;
                if (issue_cnt_q == LastIdx) begin
                    state_d     = StDrain;
                    issue_cnt_d = '0;
                end else begin
                    issue_cnt_d = issue_cnt_q + 1'b1;
                end
            end
            StDrain: begin
                if (wb_valid_o && wb_cnt_q == LastIdx) begin
                    state_d = StDone;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= StIdle;
            issue_cnt_q <= '0;
            wb_cnt_q    <= '0;
            dly_q       <= '0;
        end else begin
            state_q     <= state_d;
            issue_cnt_q <= issue_cnt_d;
            wb_cnt_q    <= wb_cnt_d;
            dly_q[0]    <= issue_valid;
            for (int i = 1; i < int'(LATENCY); i++) begin
                dly_q[i] <= dly_q[i-1];
            end
        end
    end

    assign issue_idx_o = issue_cnt_q;
    assign wb_idx_o    = wb_cnt_q;
    assign busy_o      = (state_q == StRun) || (state_q == StDrain);
    assign done_o      = (state_q == StDone);

endmodule

// File: rtl/vector_scale_mc.sv
// Multi-cycle M31 scalar-by-vector multiply: result[i] = scalar * vec[i] mod (2^31 - 1),
// one element through a shared pipelined multiplier per cycle.
module vector_scale_mc
    import m31_pkg::*;
#(
    parameter int unsigned WORD_WIDTH          = M31_WIDTH,
    parameter int unsigned VECTOR_SIZE         = 16,
    parameter int unsigned DSP_PIPELINE_STAGES = 2
) (
    input  logic                                    clk,
    input  logic                                    reset_n,
    input  logic                                    start,
    input  logic [WORD_WIDTH-1:0]                   scalar,
    input  logic [VECTOR_SIZE-1:0][WORD_WIDTH-1:0]  vec,
    output logic                                    busy,
    output logic [VECTOR_SIZE-1:0][WORD_WIDTH-1:0]  result,
    output logic                                    valid
);

    localparam int unsigned IdxW = $clog2(VECTOR_SIZE);

    logic [WORD_WIDTH-1:0]                  scalar_q;
    logic [VECTOR_SIZE-1:0][WORD_WIDTH-1:0] vec_q;
    logic [VECTOR_SIZE-1:0][WORD_WIDTH-1:0] result_q;

    logic            load;
    logic [IdxW-1:0] issue_idx;
    logic            wb_valid;
    logic [IdxW-1:0] wb_idx;
    logic [61:0]     product;
    m31_t            reduced;

    vector_issue_ctrl #(
        .VECTOR_SIZE (VECTOR_SIZE),
        .LATENCY     (DSP_PIPELINE_STAGES),
        .IDX_W       (IdxW)
    ) u_ctrl (
        .clk         (clk),
        .reset_n     (reset_n),
        .start_i     (start),
        .load_o      (load),
        .issue_idx_o (issue_idx),
        .wb_valid_o  (wb_valid),
        .wb_idx_o    (wb_idx),
        .busy_o      (busy),
        .done_o      (valid)
    );

    m31_multiplier_pl #(
        .STAGES (DSP_PIPELINE_STAGES)
    ) u_mul (
        .clk     (clk),
        .reset_n (reset_n),
        .a_i     (scalar_q),
        .b_i     (vec_q[issue_idx]),
        .p_o     (product)
    );

    m31_mod_reduce u_red (
        .x_i ({1'b0, product}),
        .r_o (reduced)
    );

    // Operands are latched on acceptance so the caller is free to change them afterwards.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            scalar_q <= '0;
            vec_q    <= '0;
            result_q <= '0;
        end else begin
            if (load) begin
                scalar_q <= scalar;
                vec_q    <= vec;
            end
            if (wb_valid) begin
                result_q[wb_idx] <= reduced;
            end
        end
    end

    assign result = result_q;

endmodule

// File: tb/tb_vector_scale_mc.sv
// Directed self-checking bench for vector_scale_mc (N=16, L=2).
module tb_vector_scale_mc;

    localparam int N = 16;
    localparam int W = 31;
    localparam logic [W-1:0] P = 31'h7FFF_FFFF;

    typedef logic [N-1:0][W-1:0] vec_t;

    logic         clk;
    logic         reset_n;
    logic         start;
    logic [W-1:0] scalar;
    vec_t         vec;
    logic         busy;
    vec_t         result;
    logic         valid;

    int n_checks;
    int n_fail;

    vector_scale_mc #(
        .WORD_WIDTH          (W),
        .VECTOR_SIZE         (N),
        .DSP_PIPELINE_STAGES (2)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (start),
        .scalar  (scalar),
        .vec     (vec),
        .busy    (busy),
        .result  (result),
        .valid   (valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Launch a job and wait for valid; lat is edges after the start edge, -1 if it never came.
    task automatic run_job(input logic [W-1:0] s, input vec_t v, output int lat, output int bcnt);
        scalar = s;
        vec    = v;
        start  = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        lat   = -1;
        bcnt  = 0;
        for (int c = 0; c < 100; c++) begin
            if (valid) begin
                lat = c;
                break;
            end
            if (busy) bcnt++;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        n_checks++;
        if (busy !== 1'b0 || valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_flags: busy=%b valid=%b, required 0 0", busy, valid);
        end
        n_checks++;
        if (result !== '0) begin
            n_fail++;
            $display("FAIL reset_result: got %h, required all zero", result);
        end
    endtask

    task automatic test_basic();
        vec_t v;
        int lat, bcnt;
        for (int i = 0; i < N; i++) v[i] = W'(i);
        run_job(31'd2, v, lat, bcnt);
        n_checks++;
        if (lat !== 18) begin
            n_fail++;
            $display("FAIL basic_latency: got %0d, required 18", lat);
        end
        n_checks++;
        if (bcnt !== 18 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_busy: high %0d cycles, busy now %b, required 18 and 0", bcnt, busy);
        end
        for (int i = 0; i < N; i++) begin
            n_checks++;
            if (result[i] !== W'(2 * i)) begin
                n_fail++;
                $display("FAIL basic_result[%0d]: got %0d, required %0d", i, result[i], 2 * i);
            end
        end
    endtask

    task automatic test_wrap();
        vec_t v;
        int lat, bcnt;
        v    = '0;
        v[0] = 31'd1;
        v[1] = P - 31'd1;
        run_job(P - 31'd1, v, lat, bcnt);
        n_checks++;
        if (lat !== 18 || result[0] !== P - 31'd1 || result[1] !== 31'd1) begin
            n_fail++;
            $display("FAIL wrap: lat=%0d r0=%h r1=%h, required 18 7ffffffe 1", lat, result[0], result[1]);
        end
        n_checks++;
        if (result[N-1:2] !== '0) begin
            n_fail++;
            $display("FAIL wrap_rest: got %h, required zero", result[N-1:2]);
        end
    endtask

    task automatic test_fold();
        vec_t v;
        vec_t ones;
        int lat, bcnt;
        for (int i = 0; i < N; i++) begin
            v[i]    = 31'h4000_0000;
            ones[i] = 31'd1;
        end
        run_job(31'd2, v, lat, bcnt);
        n_checks++;
        if (result !== ones) begin
            n_fail++;
            $display("FAIL fold_2pow31: got %h, required all 1", result);
        end
        run_job(31'd0, v, lat, bcnt);
        n_checks++;
        if (result !== '0) begin
            n_fail++;
            $display("FAIL fold_scalar0: got %h, required zero", result);
        end
        run_job(P, v, lat, bcnt);
        n_checks++;
        if (result !== '0) begin
            n_fail++;
            $display("FAIL fold_scalar_p: got %h, required zero", result);
        end
        for (int i = 0; i < N; i++) v[i] = P;
        run_job(P, v, lat, bcnt);
        n_checks++;
        if (result !== '0) begin
            n_fail++;
            $display("FAIL fold_p_times_p: got %h, required zero", result);
        end
    endtask

    task automatic test_ignore_start();
        vec_t v, v2;
        int lat;
        for (int i = 0; i < N; i++) begin
            v[i]  = W'(i + 1);
            v2[i] = 31'd9;
        end
        scalar = 31'd3;
        vec    = v;
        start  = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        lat   = -1;
        for (int c = 0; c < 100; c++) begin
            if (c == 5) begin
                start  = 1'b1;
                scalar = 31'd7;
                vec    = v2;
            end else begin
                start = 1'b0;
            end
            if (valid) begin
                lat = c;
                break;
            end
            @(posedge clk);
            #1;
        end
        start = 1'b0;
        n_checks++;
        if (lat !== 18) begin
            n_fail++;
            $display("FAIL ignore_latency: got %0d, required 18", lat);
        end
        for (int i = 0; i < N; i++) begin
            n_checks++;
            if (result[i] !== W'(3 * (i + 1))) begin
                n_fail++;
                $display("FAIL ignore_result[%0d]: got %0d, required %0d", i, result[i], 3 * (i + 1));
            end
        end
    endtask

    task automatic test_abort();
        vec_t v;
        int lat, bcnt;
        for (int i = 0; i < N; i++) v[i] = W'(i + 1);
        scalar = 31'd5;
        vec    = v;
        start  = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        n_checks++;
        if (result[0] !== 31'd5) begin
            n_fail++;
            $display("FAIL abort_prewrite: got %0d, required 5", result[0]);
        end
        reset_n = 1'b0;
        #1;
        n_checks++;
        if (busy !== 1'b0 || valid !== 1'b0 || result !== '0) begin
            n_fail++;
            $display("FAIL abort_clear: busy=%b valid=%b result=%h, required 0 0 zero", busy, valid, result);
        end
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) v[i] = W'(i + 100);
        run_job(31'd4, v, lat, bcnt);
        n_checks++;
        if (lat !== 18 || bcnt !== 18) begin
            n_fail++;
            $display("FAIL abort_rerun_timing: lat=%0d busy=%0d, required 18 18", lat, bcnt);
        end
        for (int i = 0; i < N; i++) begin
            n_checks++;
            if (result[i] !== W'(4 * (i + 100))) begin
                n_fail++;
                $display("FAIL abort_rerun[%0d]: got %0d, required %0d", i, result[i], 4 * (i + 100));
            end
        end
    endtask

    task automatic test_back_to_back();
        vec_t va, vb;
        int lat;
        for (int i = 0; i < N; i++) begin
            va[i] = W'(i);
            vb[i] = W'(i + 1);
        end
        scalar = 31'd2;
        vec    = va;
        start  = 1'b1;
        lat    = -1;
        for (int c = 0; c < 100; c++) begin
            @(posedge clk);
            #1;
            if (valid) begin
                lat = c;
                break;
            end
        end
        n_checks++;
        if (lat !== 18 || result[5] !== 31'd10) begin
            n_fail++;
            $display("FAIL b2b_first: lat=%0d r5=%0d, required 18 10", lat, result[5]);
        end
        scalar = 31'd3;
        vec    = vb;
        @(posedge clk);
        #1;
        start = 1'b0;
        n_checks++;
        if (valid !== 1'b0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_relaunch: valid=%b busy=%b, required 0 1", valid, busy);
        end
        lat = -1;
        for (int c = 0; c < 100; c++) begin
            if (valid) begin
                lat = c;
                break;
            end
            @(posedge clk);
            #1;
        end
        n_checks++;
        if (lat !== 18) begin
            n_fail++;
            $display("FAIL b2b_second_latency: got %0d, required 18", lat);
        end
        for (int i = 0; i < N; i++) begin
            n_checks++;
            if (result[i] !== W'(3 * (i + 1))) begin
                n_fail++;
                $display("FAIL b2b_result[%0d]: got %0d, required %0d", i, result[i], 3 * (i + 1));
            end
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset_n  = 1'b0;
        start    = 1'b0;
        scalar   = '0;
        vec      = '0;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        test_reset();
        test_basic();
        test_wrap();
        test_fold();
        test_ignore_start();
        test_abort();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
